// File: rtl/pipelined_cla_addsub.sv
// Segment-pipelined carry-lookahead adder/subtractor with valid/ready handshakes and C/V/Z flags.
// Optional signed saturation is enabled by defining PCLA_SAT_EN (adds the Sat input).
module pipelined_cla_addsub #(
    parameter int WIDTH = 32,
    parameter int SEG_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] In1,
    input  logic [WIDTH-1:0] In2,
    input  logic             CI,
    input  logic             Sub,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] Out,
    output logic             CO,
    output logic             OV,
    output logic             Z
`ifdef PCLA_SAT_EN
    ,
    input  logic             Sat
`endif
);

    localparam int LAT = WIDTH / SEG_W;
    localparam int NG  = SEG_W / 4;

    if ((SEG_W <= 0) || ((SEG_W % 4) != 0)) begin : g_bad_seg
        $error("SEG_W must be a positive multiple of 4");
    end
    if ((WIDTH % SEG_W) != 0) begin : g_bad_width
        $error("WIDTH must be a multiple of SEG_W");
    end

    // One SEG_W-bit slice built from 4-bit lookahead groups; returns {carry_out, sum}.
    function automatic logic [SEG_W:0] cla_seg(input logic [SEG_W-1:0] a,
                                               input logic [SEG_W-1:0] b,
                                               input logic             cin);
        logic [SEG_W-1:0] s;
        logic [3:0]       p;
        logic [3:0]       g;
        logic [4:0]       c;
        logic             cg;
        s  = '0;
        cg = cin;
        for (int j = 0; j < NG; j++) begin
            p    = a[4*j +: 4] ^ b[4*j +: 4];
            g    = a[4*j +: 4] & b[4*j +: 4];
            c[0] = cg;
            c[1] = g[0] | (p[0] & cg);
            c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cg);
            c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cg);
            c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                 | ((&p) & cg);
            s[4*j +: 4] = p ^ c[3:0];
            cg = c[4];
        end
        return {cg, s};
    endfunction

    logic sat_in;
`ifdef PCLA_SAT_EN
    assign sat_in = Sat;
`else
    assign sat_in = 1'b0;
`endif

    // Stage k holds a beat whose segments 0..k-1 are already resolved into r_q[k].
    logic [WIDTH-1:0] a_q [LAT];
    logic [WIDTH-1:0] a_d [LAT];
    logic [WIDTH-1:0] b_q [LAT];
    logic [WIDTH-1:0] b_d [LAT];
    logic [WIDTH-1:0] r_q [LAT];
    logic [WIDTH-1:0] r_d [LAT];
    logic [LAT-1:0]   vld_q, vld_d;
    logic [LAT-1:0]   cy_q, cy_d;
    logic [LAT-1:0]   sat_q, sat_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             co_q, co_d;
    logic             ov_q, ov_d;
    logic             z_q, z_d;

    logic [WIDTH-1:0] seg_sum;
    logic [LAT-1:0]   seg_co;

    for (genvar gi = 0; gi < LAT; gi++) begin : g_seg
        logic [SEG_W:0] seg_res;
        assign seg_res = cla_seg(a_q[gi][gi*SEG_W +: SEG_W], b_q[gi][gi*SEG_W +: SEG_W], cy_q[gi]);
        assign seg_sum[gi*SEG_W +: SEG_W] = seg_res[SEG_W-1:0];
        assign seg_co[gi] = seg_res[SEG_W];
    end

    logic             adv;
    logic [WIDTH-1:0] fin_raw;
    logic [WIDTH-1:0] fin_out;
    logic             fin_cm;
    logic             fin_ov;

    assign adv     = !(out_valid_q && !OutReady);
    assign InReady = adv;

    // Final segment and flags; the carry into the MSB is recovered as sum ^ propagate.
    always_comb begin
        fin_raw = r_q[LAT-1];
        fin_raw[(LAT-1)*SEG_W +: SEG_W] = seg_sum[(LAT-1)*SEG_W +: SEG_W];
        fin_cm  = a_q[LAT-1][WIDTH-1] ^ b_q[LAT-1][WIDTH-1] ^ fin_raw[WIDTH-1];
        fin_ov  = fin_cm ^ seg_co[LAT-1];
        fin_out = fin_raw;
        if (sat_q[LAT-1] && fin_ov) begin
            fin_out = {~fin_raw[WIDTH-1], {(WIDTH-1){fin_raw[WIDTH-1]}}};
        end
    end

    always_comb begin
        a_d         = a_q;
        b_d         = b_q;
        r_d         = r_q;
        vld_d       = vld_q;
        cy_d        = cy_q;
        sat_d       = sat_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        co_d        = co_q;
        ov_d        = ov_q;
        z_d         = z_q;
        if (adv) begin
            vld_d[0] = InValid;
            a_d[0]   = In1;
            b_d[0]   = In2 ^ {WIDTH{Sub}};
            cy_d[0]  = Sub | CI;
            r_d[0]   = '0;
            sat_d[0] = sat_in;
            for (int k = 1; k < LAT; k++) begin
                vld_d[k] = vld_q[k-1];
                a_d[k]   = a_q[k-1];
                b_d[k]   = b_q[k-1];
                sat_d[k] = sat_q[k-1];
                cy_d[k]  = seg_co[k-1];
                r_d[k]   = r_q[k-1];
                r_d[k][(k-1)*SEG_W +: SEG_W] = seg_sum[(k-1)*SEG_W +: SEG_W];
            end
            out_valid_d = vld_q[LAT-1];
            if (vld_q[LAT-1]) begin
                out_d = fin_out;
                co_d  = seg_co[LAT-1];
                ov_d  = fin_ov;
                z_d   = ~|fin_out;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int k = 0; k < LAT; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                r_q[k] <= '0;
            end
            vld_q       <= '0;
            cy_q        <= '0;
            sat_q       <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            co_q        <= 1'b0;
            ov_q        <= 1'b0;
            z_q         <= 1'b0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            r_q         <= r_d;
            vld_q       <= vld_d;
            cy_q        <= cy_d;
            sat_q       <= sat_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            co_q        <= co_d;
            ov_q        <= ov_d;
            z_q         <= z_d;
        end
    end

    assign OutValid = out_valid_q;
    assign Out      = out_q;
    assign CO       = co_q;
    assign OV       = ov_q;
    assign Z        = z_q;

endmodule
